// File: rtl/ftq_brwb_sched_pkg.sv
// Shared backend types for branch writeback scheduling: ROB index, writeback payload, squash info.
package ftq_brwb_sched_pkg;
    localparam int ROB_IDX_W = 5;
    localparam int FTQ_IDX_W = 4;

    typedef struct packed {
        logic                 flg;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef struct packed {
        logic [FTQ_IDX_W-1:0] ftq_idx;
        robIdx_t              rob_idx;
        logic                 has_mispred;
        logic [31:0]          target;
    } branchwbInfo_t;

    typedef struct packed {
        robIdx_t rob_idx;
    } squashInfo_t;

    // Wrap flag flips each ROB lap, so a differing flag inverts the index compare.
    function automatic logic rob_older(robIdx_t a, robIdx_t b);
        return (a.flg == b.flg) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction
endpackage

// File: rtl/ftq_brwb_sched_replay_buf.sv
// Age-ordered compacting replay buffer: squash-filtered view, dequeue mask, up to BRU_NUM enqueues.
module brwb_replay_buf import ftq_brwb_sched_pkg::*; #(
    parameter int BRU_NUM   = 2,
    parameter int BUF_DEPTH = 4,
    parameter int FW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                squash_vld,
    input  robIdx_t                             squash_rob,
    input  logic          [BUF_DEPTH-1:0]       deq,
    input  logic          [BRU_NUM-1:0]         enq_vld,
    input  branchwbInfo_t [BRU_NUM-1:0]         enq_info,
    output logic          [BUF_DEPTH-1:0]       ent_vld,
    output branchwbInfo_t [BUF_DEPTH-1:0]       ent,
    output logic          [FW-1:0]              free_nxt
);
    localparam int N  = BUF_DEPTH + BRU_NUM;
    localparam int PW = $clog2(N + 1);

    logic          [BUF_DEPTH-1:0]       vld_q, vld_d;
    branchwbInfo_t [BUF_DEPTH-1:0]       ent_q, ent_d;
    logic          [N-1:0]               m_vld;
    branchwbInfo_t [N-1:0]               m_info;
    logic          [N-1:0][PW-1:0]       m_pos;
    logic          [PW-1:0]              m_cnt;

    assign ent = ent_q;

    always_comb begin
        ent_vld = '0;
        for (int i = 0; i < BUF_DEPTH; i++)
            ent_vld[i] = vld_q[i] && !(squash_vld && rob_older(squash_rob, ent_q[i].rob_idx));
    end

    // Survivors and new entries are merged by rank: slot = number of older live items.
    always_comb begin
        m_vld  = '0;
        m_info = '0;
        m_pos  = '0;
        m_cnt  = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            m_vld[i]  = ent_vld[i] && !deq[i];
            m_info[i] = ent_q[i];
        end
        for (int j = 0; j < BRU_NUM; j++) begin
            m_vld[BUF_DEPTH+j]  = enq_vld[j];
            m_info[BUF_DEPTH+j] = enq_info[j];
        end
        for (int i = 0; i < N; i++) begin
            m_cnt = m_cnt + PW'(m_vld[i]);
            for (int j = 0; j < N; j++)
                if (m_vld[j] && rob_older(m_info[j].rob_idx, m_info[i].rob_idx))
                    m_pos[i] = m_pos[i] + PW'(1);
        end
    end

    always_comb begin
        vld_d = '0;
        ent_d = ent_q;
        for (int p = 0; p < BUF_DEPTH; p++)
            for (int i = 0; i < N; i++)
                if (m_vld[i] && m_pos[i] == PW'(p)) begin
                    vld_d[p] = 1'b1;
                    ent_d[p] = m_info[i];
                end
    end

    assign free_nxt = (m_cnt > PW'(BUF_DEPTH)) ? '0 : FW'(PW'(BUF_DEPTH) - m_cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            ent_q <= '0;
        end else begin
            vld_q <= vld_d;
            ent_q <= ent_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) m_cnt <= PW'(BUF_DEPTH));
endmodule

// File: rtl/ftq_brwb_sched.sv
// Schedules BRU writebacks onto FTQ write ports so no two same-cycle writes hit one ftq_idx.
module ftq_brwb_sched import ftq_brwb_sched_pkg::*; #(
    parameter int BRU_NUM   = 2,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_squash_vld,
    input  squashInfo_t                   i_squashInfo,
    input  logic          [BRU_NUM-1:0]   i_branchwb_vld,
    input  branchwbInfo_t [BRU_NUM-1:0]   i_branchwbInfo,
    output logic          [BRU_NUM-1:0]   o_branchwb_vld,
    output branchwbInfo_t [BRU_NUM-1:0]   o_branchwbInfo,
    output logic                          o_bru_stall,
    output logic          [CNT_W-1:0]     o_conflict_cnt
);
    localparam int N  = BUF_DEPTH + BRU_NUM;
    localparam int RW = $clog2(BRU_NUM + 1);
    localparam int FW = $clog2(BUF_DEPTH + 1);

    logic          [BUF_DEPTH-1:0]    buf_vld;
    branchwbInfo_t [BUF_DEPTH-1:0]    buf_ent;
    logic          [FW-1:0]           free_nxt;
    logic          [BRU_NUM-1:0]      in_alive;
    logic          [BRU_NUM-1:0][RW-1:0] in_rank;
    logic          [N-1:0]            c_vld, c_gnt;
    branchwbInfo_t [N-1:0]            c_info;
    logic          [BRU_NUM-1:0]      out_vld_d, enq_vld;
    branchwbInfo_t [BRU_NUM-1:0]      out_info_d, enq_info;
    logic          [RW-1:0]           enq_n;
    logic          [CNT_W:0]          cnt_sum;
    logic                             hit, placed;

    // Candidate list: buffer entries (already age-ordered), then live inputs sorted by age.
    always_comb begin
        in_alive = '0;
        in_rank  = '0;
        c_vld    = '0;
        c_info   = '0;
        for (int j = 0; j < BRU_NUM; j++)
            in_alive[j] = i_branchwb_vld[j] &&
                          !(i_squash_vld && rob_older(i_squashInfo.rob_idx, i_branchwbInfo[j].rob_idx));
        for (int j = 0; j < BRU_NUM; j++)
            for (int k = 0; k < BRU_NUM; k++)
                if (in_alive[k] && rob_older(i_branchwbInfo[k].rob_idx, i_branchwbInfo[j].rob_idx))
                    in_rank[j] = in_rank[j] + RW'(1);
        for (int i = 0; i < BUF_DEPTH; i++) begin
            c_vld[i]  = buf_vld[i];
            c_info[i] = buf_ent[i];
        end
        for (int r = 0; r < BRU_NUM; r++)
            for (int j = 0; j < BRU_NUM; j++)
                if (in_alive[j] && in_rank[j] == RW'(r)) begin
                    c_vld[BUF_DEPTH+r]  = 1'b1;
                    c_info[BUF_DEPTH+r] = i_branchwbInfo[j];
                end
    end

    // Ports fill in walk order; a candidate whose ftq_idx is already on a port waits.
    always_comb begin
        out_vld_d  = '0;
        out_info_d = '0;
        c_gnt      = '0;
        hit        = 1'b0;
        placed     = 1'b0;
        for (int c = 0; c < N; c++) begin
            hit = 1'b0;
            for (int k = 0; k < BRU_NUM; k++)
                if (out_vld_d[k] && out_info_d[k].ftq_idx == c_info[c].ftq_idx)
                    hit = 1'b1;
            placed = 1'b0;
            if (c_vld[c] && !hit)
                for (int k = 0; k < BRU_NUM; k++)
                    if (!placed && !out_vld_d[k]) begin
                        out_vld_d[k]  = 1'b1;
                        out_info_d[k] = c_info[c];
                        c_gnt[c]      = 1'b1;
                        placed        = 1'b1;
                    end
        end
    end

    assign enq_vld  = c_vld[N-1:BUF_DEPTH] & ~c_gnt[N-1:BUF_DEPTH];
    assign enq_info = c_info[N-1:BUF_DEPTH];

    always_comb begin
        enq_n = '0;
        for (int j = 0; j < BRU_NUM; j++)
            enq_n = enq_n + RW'(enq_vld[j]);
        cnt_sum = {1'b0, o_conflict_cnt} + (CNT_W+1)'(enq_n);
    end

    brwb_replay_buf #(
        .BRU_NUM   (BRU_NUM),
        .BUF_DEPTH (BUF_DEPTH),
        .FW        (FW)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .squash_vld (i_squash_vld),
        .squash_rob (i_squashInfo.rob_idx),
        .deq        (c_gnt[BUF_DEPTH-1:0]),
        .enq_vld    (enq_vld),
        .enq_info   (enq_info),
        .ent_vld    (buf_vld),
        .ent        (buf_ent),
        .free_nxt   (free_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_branchwb_vld <= '0;
            o_branchwbInfo <= '0;
            o_bru_stall    <= 1'b0;
            o_conflict_cnt <= '0;
        end else begin
            o_branchwb_vld <= out_vld_d;
            o_branchwbInfo <= out_info_d;
            o_bru_stall    <= free_nxt < FW'(BRU_NUM);
            o_conflict_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    a_no_issue_on_stall: assert property (@(posedge clk) disable iff (!rst)
        o_bru_stall |-> (i_branchwb_vld == '0));
endmodule
